sm_result_acc: RTL and testbench
================================

// Module: sm_result_acc
// PURPOSE
//  Downstream stage of the sign-magnitude add/sub unit. Accepts its DW-bit
//  sign-magnitude results over a valid/ready handshake and converts each to
//  two's complement. Accumulates the results of one frame (terminated by
//  in_last) into a saturating AW-bit accumulator and emits one registered
//  frame sum, with beat count and saturation flag, per frame.
// PARAMETERS
//  DW  16  input word width; bit DW-1 = sign, bits DW-2:0 = magnitude
//  GW  4   accumulator guard bits; localparam AW = DW+GW (output width)
//  CW  8   beat-counter width
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       reset, asynchronous, active-high
//  in_valid  in   1       in_data/in_last valid
//  in_ready  out  1       stage can accept a beat
//  in_data   in   DW      sign-magnitude result from the add/sub unit
//  in_last   in   1       beat is the final beat of its frame
//  out_valid out  1       frame result valid
//  out_ready in   1       consumer accepts frame result
//  out_data  out  AW      frame sum, two's complement
//  out_sat   out  1       saturation occurred at any point in the frame
//  out_cnt   out  CW      number of beats in the frame, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sat=0, out_cnt=0. Internal acc=0,
//    sat_r=0, cnt_r=0. in_ready is combinational from out_valid/out_ready.
//  - Beat accepted when in_valid & in_ready.
//    in_ready = ~out_valid | out_ready.
//  - Conversion: mag = in_data[DW-2:0], zero-extended to AW.
//    val = in_data[DW-1] ? -mag : mag. Negative zero (sign=1, mag=0) -> 0.
//  - Step: s = acc + val, computed in AW+1 bits.
//    If s > 2^(AW-1)-1 then s = 2^(AW-1)-1 and sat_step=1.
//    If s < -2^(AW-1) then s = -2^(AW-1) and sat_step=1.
//    Clamping is applied per beat; later beats may pull the sum back in
//    range, but the saturation flag stays set for the rest of the frame.
//  - Non-last beat accepted: acc <= s; sat_r <= sat_r|sat_step;
//    cnt_r <= cnt_r+1, holding at 2^CW-1.
//  - Last beat accepted in cycle N:
//    * out_data <= s; out_sat <= sat_r|sat_step; out_cnt <= cnt_r+1
//      (saturating); out_valid=1 from cycle N+1.
//    * acc, sat_r, cnt_r <= 0 in the same edge.
//    * Latency: last beat to out_valid is 1 cycle.
//  - Output register:
//    * Holds its value while out_valid & ~out_ready.
//    * out_valid clears on handshake unless a last beat is accepted in the
//      same cycle; in that case the register reloads and out_valid stays 1.
//  - While out_valid & ~out_ready, in_ready=0 for all beats (last and
//    non-last): whole-stage stall, no partial accumulation.
//  - Single-beat frame (in_last on first beat): out_data=val, out_cnt=1.
//  - Reset asserted mid-frame or with a result pending discards everything;
//    the first beat after reset starts a new frame.
//  - No combinational path from in_* to out_*.
// TESTING
//  1 Beats 0x0005, 0x8003(last) -> one result: out_data=0x00002, out_cnt=2,
//    out_sat=0, out_valid the cycle after the last beat.
//  2 Single beat 0x8000(last) -> out_data=0x00000, out_cnt=1, out_sat=0.
//  3 17 beats of 0x7FFF, last on the 17th -> out_data=0x7FFFF, out_sat=1.
//    17 beats of 0xFFFF -> out_data=0x80000, out_sat=1.
//  4 Saturate high, then 0xFFFF(last) -> out_data=0x7FFFF-0x7FFF=0x78000,
//    out_sat=1 (sticky).
//  5 out_ready=0 for 5 cycles with a result pending -> in_ready=0 and
//    out_data stable. Then out_ready=1 in the same cycle a new last beat
//    arrives -> out_valid stays 1 and the new sum loads.
//  6 300-beat frame of 0x0000 -> out_cnt=255. Reset pulse after 3 beats of
//    0x0001, then 0x0002(last) -> out_data=0x00002, out_cnt=1.

Source files
------------

// File: rtl/sm_result_acc.sv
// Frame accumulator for sign-magnitude results: converts each beat to two's
// complement, sums a frame with per-beat saturation, and registers one result per frame.
module sm_result_acc #(
    parameter int DW = 16,
    parameter int GW = 4,
    parameter int CW = 8,
    localparam int AW = DW + GW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_sat,
    output logic [CW-1:0] out_cnt
);

    localparam logic [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW-1:0] acc_q, acc_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic          out_sat_q, out_sat_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;

    logic [AW-1:0] mag;
    logic [AW-1:0] val;
    logic [AW:0]   sum_wide;
    logic [AW-1:0] sum_clamped;
    logic          sat_step;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          out_hs;

    // A pending result stalls the whole stage so no beat can slip past it.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;

    // Negative zero negates to zero, so it needs no special case.
    assign mag      = {{(GW+1){1'b0}}, in_data[DW-2:0]};
    assign val      = in_data[DW-1] ? (AW'(0) - mag) : mag;
    assign sum_wide = {acc_q[AW-1], acc_q} + {val[AW-1], val};
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sat_step    = 1'b0;
        sum_clamped = sum_wide[AW-1:0];
        if (sum_wide[AW] != sum_wide[AW-1]) begin
            sat_step    = 1'b1;
            sum_clamped = sum_wide[AW] ? SUM_MIN : SUM_MAX;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_cnt_d   = out_cnt_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_clamped;
            out_sat_d   = sat_q | sat_step;
            out_cnt_d   = cnt_inc;
            acc_d       = '0;
            sat_d       = 1'b0;
            cnt_d       = '0;
        end else if (accept) begin
            acc_d = sum_clamped;
            sat_d = sat_q | sat_step;
            cnt_d = cnt_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_sm_result_acc.sv
// Bench for sm_result_acc: directed scenarios plus randomized traffic, all
// checked against an integer frame model that tracks the single result slot.
module tb_sm_result_acc;

    localparam int MAXV = 524287;
    localparam int MINV = -524288;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic        out_sat;
    logic [7:0]  out_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model: running frame sum, flags, and the one result slot.
    int m_acc, m_cnt, m_data, m_ocnt;
    bit m_sat, m_osat, m_pend;

    always #5 clk = ~clk;

    sm_result_acc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_cnt(out_cnt)
    );

    wire [29:0] obs_vec = {out_valid, out_sat, out_cnt, out_data};

    function automatic logic [29:0] exp_vec();
        logic [7:0]  c = 8'(m_ocnt);
        logic [19:0] d = 20'(m_data);
        return {m_pend, m_osat, c, d};
    endfunction

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_sat = 0;
        m_data = 0; m_ocnt = 0; m_osat = 0; m_pend = 0;
    endtask

    // Drives one cycle, advances the model, returns the acceptance decision and in_ready.
    task automatic drive(input bit v, input logic [15:0] d, input bit l, input bit ordy,
                         output bit accepted, output bit ir_seen, output bit ir_exp);
        int  val, s;
        bit  step, hs;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        @(negedge clk);
        ir_seen  = in_ready;
        ir_exp   = !m_pend || ordy;
        accepted = v && ir_exp;
        hs       = m_pend && ordy;
        val = d[15] ? -int'(d[14:0]) : int'(d[14:0]);
        s = m_acc + val;
        step = 0;
        if (s > MAXV) begin s = MAXV; step = 1; end
        else if (s < MINV) begin s = MINV; step = 1; end
        if (accepted && l) begin
            m_data = s; m_osat = m_sat | step;
            m_ocnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            m_acc = 0; m_sat = 0; m_cnt = 0; m_pend = 1;
        end else begin
            if (accepted) begin
                m_acc = s; m_sat = m_sat | step;
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end
            if (hs) m_pend = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] d, input bit l, input bit ordy);
        bit a, ir, ire;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, d, l, ordy, a, ir, ire);
            if (a) begin
                in_valid = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL send_timeout: beat %h not accepted within 20 cycles", d);
        in_valid = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        bit a, ir, ire;
        drive(1'b0, 16'h0000, 1'b0, ordy, a, ir, ire);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec !== 30'd0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0", obs_vec);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send(16'h0005, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        send(16'h8003, 1'b1, 1'b0);
        checks++;
        if (obs_vec !== {1'b1, 1'b0, 8'd2, 20'h00002} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL basic_result: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_single();
        send(16'h8000, 1'b1, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b0, 8'd1, 20'h00000} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL single_negzero: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) send(16'h7FFF, i == 16, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b1, 8'd17, 20'h7FFFF} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL sat_high: got %h want %h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 17; i++) send(16'hFFFF, i == 16, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b1, 8'd17, 20'h80000} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL sat_low: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
    endtask

    task automatic test_sticky();
        for (int i = 0; i < 17; i++) send(16'h7FFF, 1'b0, 1'b1);
        send(16'hFFFF, 1'b1, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b1, 8'd18, 20'h78000} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL sticky_sat: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        bit a, ir, ire;
        send(16'h0004, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0007, 1'b1, 1'b0, a, ir, ire);
            checks++;
            if (ir !== 1'b0 || ir !== ire) begin
                failures++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, ir);
            end
            checks++;
            if (obs_vec !== {1'b1, 1'b0, 8'd1, 20'h00004} || obs_vec !== exp_vec()) begin
                failures++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        drive(1'b1, 16'h0007, 1'b1, 1'b1, a, ir, ire);
        checks++;
        if (obs_vec !== {1'b1, 1'b0, 8'd1, 20'h00007} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL reload_same_cycle: got %h want %h", obs_vec, exp_vec());
        end
        in_valid = 1'b0;
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reload_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_count_and_reset();
        for (int i = 0; i < 300; i++) send(16'h0000, i == 299, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b0, 8'd255, 20'h00000} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL count_saturate: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
        for (int i = 0; i < 3; i++) send(16'h0001, 1'b0, 1'b1);
        #2 rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (obs_vec !== 30'd0) begin
            failures++; $display("FAIL async_reset: got %h want 0", obs_vec);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'h0002, 1'b1, 1'b1);
        checks++;
        if (obs_vec !== {1'b1, 1'b0, 8'd1, 20'h00002} || obs_vec !== exp_vec()) begin
            failures++; $display("FAIL post_reset_frame: got %h want %h", obs_vec, exp_vec());
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        bit a, ir, ire, v, l, ordy;
        logic [15:0] d;
        for (int i = 0; i < 600; i++) begin
            v    = $urandom_range(0, 3) != 0;
            l    = $urandom_range(0, 7) == 0;
            ordy = $urandom_range(0, 3) != 0;
            d    = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d[14:0] = 15'h7FFF;
            drive(v, d, l, ordy, a, ir, ire);
            checks++;
            if (ir !== ire) begin
                failures++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, ir, ire);
            end
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++; $display("FAIL rand_out[%0d]: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_saturation();
        test_sticky();
        test_back_to_back();
        test_count_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
